mem_loader_ctrl: RTL and testbench

MEM_LOADER_CTRL -- requirements
Module: mem_loader_ctrl

---
 rtl/mem_loader_pkg.sv | 28 ++
 rtl/mem_loader_ctrl_timeout_counter.sv | 30 +++
 rtl/mem_loader_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_loader_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package mem_loader_pkg;

  localparam logic [7:0]  MAGIC_BYTE = 8'hA5;
  localparam int unsigned LEN_BYTES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN_OVF = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  // True while a frame is in flight and the idle watchdog must run.
  function automatic logic frame_active(input state_e s);
    return (s == LEN) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/mem_loader_ctrl_timeout_counter.sv
// Idle watchdog: down-counter reloaded on restart, expired at terminal count.
module timeout_counter #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  // Loading CYCLES-1 makes expired rise during the CYCLES-th idle cycle.
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else if (restart) begin
      cnt_q <= LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/mem_loader_ctrl.sv
// Loads a framed byte stream into instruction memory while holding the core in reset.
//   state | meaning
//   IDLE  | no frame seen since reset, waiting for magic byte
//   LEN   | collecting the 4-byte little-endian payload length
//   DATA  | writing payload bytes and accumulating the checksum
//   CHECK | comparing the trailing checksum byte
//   DONE  | image loaded, core released, waiting for magic byte
//   ERROR | load failed, core held, waiting for magic byte
module mem_loader_ctrl
  import mem_loader_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE    = 8196,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] mem_loader_write_addr,
  output logic [7:0]  mem_loader_write_data,
  output logic        mem_loader_write_en,
  output logic        cpu_reset_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [1:0]  err_code
);

  localparam logic [31:0] MEM_SIZE_W = 32'(MEMORY_SIZE);
  localparam logic [31:0] LEN_LAST   = 32'(LEN_BYTES - 1);

  state_e      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        rx_ready_q;
  logic        wen_q, wen_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  err_code_e   err_q, err_d;

  logic        hs;
  logic        active;
  logic        expired;
  logic [31:0] len_full;

  assign hs       = rx_valid && rx_ready_q;
  assign active   = frame_active(state_q);
  // Length arrives LSB first, so each new byte enters at the top.
  assign len_full = {rx_data, len_q[31:8]};

  timeout_counter #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .restart (hs || !active),
    .enable  (active),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    error_d = error_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (hs && (rx_data == MAGIC_BYTE)) begin
          state_d = LEN;
          len_d   = '0;
          cnt_d   = '0;
          csum_d  = '0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          err_d   = ERR_NONE;
        end
      end
      LEN: begin
        if (hs) begin
          len_d = len_full;
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == LEN_LAST) begin
            cnt_d = '0;
            if (len_full > MEM_SIZE_W) begin
              state_d = ERROR;
              error_d = 1'b1;
              err_d   = ERR_LEN_OVF;
            end else if (len_full == '0) begin
              state_d = CHECK;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (hs) begin
          wen_d   = 1'b1;
          waddr_d = BASE_ADDR + cnt_q;
          wdata_d = rx_data;
          csum_d  = csum_q + rx_data;
          cnt_d   = cnt_q + 32'd1;
          if (cnt_q == (len_q - 32'd1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (hs) begin
          if (rx_data == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A handshake in the same cycle always wins over the watchdog.
    if (active && !hs && expired) begin
      state_d = ERROR;
      error_d = 1'b1;
      err_d   = ERR_TIMEOUT;
      wen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      cnt_q      <= '0;
      csum_q     <= '0;
      rx_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      rx_ready_q <= 1'b1;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready              = rx_ready_q;
  assign mem_loader_write_en   = wen_q;
  assign mem_loader_write_addr = waddr_q;
  assign mem_loader_write_data = wdata_q;
  assign cpu_reset_hold        = hold_q;
  assign load_done             = done_q;
  assign load_error            = error_q;
  assign err_code              = err_q;

endmodule

// File: tb/tb_mem_loader_ctrl.sv
// Directed frames with a write scoreboard and status checks for mem_loader_ctrl.
module tb_mem_loader_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] write_addr;
  logic [7:0]  write_data;
  logic        write_en;
  logic        cpu_reset_hold;
  logic        load_done;
  logic        load_error;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];
  logic [39:0] mon_exp;

  logic [7:0]  frame_good [10];
  logic [7:0]  frame_len0 [6];
  logic [7:0]  frame_ovf  [5];
  logic [39:0] wr_good    [4];

  always #5 clk = ~clk;

  mem_loader_ctrl #(
    .MEMORY_SIZE    (8196),
    .BASE_ADDR      (32'h0),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rx_data               (rx_data),
    .rx_valid              (rx_valid),
    .rx_ready              (rx_ready),
    .mem_loader_write_addr (write_addr),
    .mem_loader_write_data (write_data),
    .mem_loader_write_en   (write_en),
    .cpu_reset_hold        (cpu_reset_hold),
    .load_done             (load_done),
    .load_error            (load_error),
    .err_code              (err_code)
  );

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write",
                 write_addr, write_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({write_addr, write_data} !== mon_exp) begin
          errors++;
          $display("FAIL write: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                   write_addr, write_data, mon_exp[39:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while ((rx_ready !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake_wait: got rx_ready=%b after %0d cycles, required 1", rx_ready, n);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_good_writes();
    for (int i = 0; i < 4; i++) exp_q.push_back(wr_good[i]);
  endtask

  task automatic drain_check(input string name);
    repeat (2) tick();
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_good = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h18};
    frame_len0 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame_ovf  = '{8'hA5, 8'h05, 8'h20, 8'h00, 8'h00};
    wr_good    = '{{32'd0, 8'h13}, {32'd1, 8'h05}, {32'd2, 8'h00}, {32'd3, 8'h00}};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();

    check("rst_rx_ready",   32'(rx_ready),       32'd0);
    check("rst_write_en",   32'(write_en),       32'd0);
    check("rst_write_addr", write_addr,          32'd0);
    check("rst_write_data", 32'(write_data),     32'd0);
    check("rst_hold",       32'(cpu_reset_hold), 32'd0);
    check("rst_done",       32'(load_done),      32'd0);
    check("rst_error",      32'(load_error),     32'd0);
    check("rst_err_code",   32'(err_code),       32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    // Good frame: four writes, core released at the end
    send_byte(frame_good[0]);
    check("good_hold_during", 32'(cpu_reset_hold), 32'd1);
    check("good_done_during", 32'(load_done),      32'd0);
    push_good_writes();
    for (int i = 1; i < 10; i++) send_byte(frame_good[i]);
    check("good_done",     32'(load_done),      32'd1);
    check("good_error",    32'(load_error),     32'd0);
    check("good_err_code", 32'(err_code),       32'd0);
    check("good_hold_end", 32'(cpu_reset_hold), 32'd0);
    drain_check("good_writes_left");

    // Same frame, checksum off by one
    send_byte(frame_good[0]);
    check("csum_done_cleared", 32'(load_done), 32'd0);
    push_good_writes();
    for (int i = 1; i < 9; i++) send_byte(frame_good[i]);
    send_byte(8'h19);
    check("csum_error",    32'(load_error),     32'd1);
    check("csum_err_code", 32'(err_code),       32'd2);
    check("csum_hold",     32'(cpu_reset_hold), 32'd1);
    check("csum_done",     32'(load_done),      32'd0);
    drain_check("csum_writes_left");

    // Length 8197 exceeds the 8196-byte memory
    for (int i = 0; i < 5; i++) send_byte(frame_ovf[i]);
    check("ovf_error",    32'(load_error),     32'd1);
    check("ovf_err_code", 32'(err_code),       32'd1);
    check("ovf_hold",     32'(cpu_reset_hold), 32'd1);
    send_byte(8'h13);
    drain_check("ovf_writes");

    // Junk before magic is discarded; empty payload loads cleanly
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_err_code_kept", 32'(err_code), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(frame_len0[i]);
    check("len0_done",     32'(load_done),      32'd1);
    check("len0_error",    32'(load_error),     32'd0);
    check("len0_err_code", 32'(err_code),       32'd0);
    check("len0_hold",     32'(cpu_reset_hold), 32'd0);
    drain_check("len0_writes");

    // Stall after two payload bytes until the watchdog fires
    exp_q.push_back(wr_good[0]);
    exp_q.push_back(wr_good[1]);
    for (int i = 0; i < 7; i++) send_byte(frame_good[i]);
    repeat (TO - 1) tick();
    check("to_error_early", 32'(load_error), 32'd0);
    tick();
    check("to_error",    32'(load_error),     32'd1);
    check("to_err_code", 32'(err_code),       32'd3);
    check("to_hold",     32'(cpu_reset_hold), 32'd1);
    drain_check("to_writes_left");

    push_good_writes();
    for (int i = 0; i < 10; i++) send_byte(frame_good[i]);
    check("recover_done",     32'(load_done), 32'd1);
    check("recover_err_code", 32'(err_code),  32'd0);
    drain_check("recover_writes_left");

    // Reset in the middle of DATA aborts the frame
    exp_q.push_back(wr_good[0]);
    exp_q.push_back(wr_good[1]);
    for (int i = 0; i < 7; i++) send_byte(frame_good[i]);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    tick();
    check("midrst_rx_ready", 32'(rx_ready),       32'd0);
    check("midrst_write_en", 32'(write_en),       32'd0);
    check("midrst_addr",     write_addr,          32'd0);
    check("midrst_data",     32'(write_data),     32'd0);
    check("midrst_hold",     32'(cpu_reset_hold), 32'd0);
    check("midrst_error",    32'(load_error),     32'd0);
    check("midrst_err_code", 32'(err_code),       32'd0);
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    check("midrst_ready_low", 32'(rx_ready), 32'd0);
    tick();
    check("midrst_ready_back", 32'(rx_ready), 32'd1);
    for (int i = 7; i < 10; i++) send_byte(frame_good[i]);
    check("midrst_done", 32'(load_done),      32'd0);
    check("midrst_hold_after", 32'(cpu_reset_hold), 32'd0);
    drain_check("midrst_writes");

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
